// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if: operand/result bundle for the pipelined adder/subtractor.
//
// Build option: PIPE_ADDSUB_OVF_EN adds the signed-overflow flag V.
//
// Signals
//   I0, I1     operand A / operand B (WIDTH bits)
//   CIN        carry-in (add) / borrow-in (subtract)
//   SUB        0 = add, 1 = subtract
//   VALID_IN   operands valid this cycle
//   HOLD       1 = freeze the whole pipeline
//   O          result (WIDTH bits)
//   COUT       carry-out (add) / borrow-out (subtract)
//   VALID_OUT  O/COUT valid
//   V          signed overflow (only with PIPE_ADDSUB_OVF_EN)
//
// Modports
//   master  operand source / result consumer
//   slave   the arithmetic pipeline
interface pipe_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             CIN;
    logic             SUB;
    logic             VALID_IN;
    logic             HOLD;
    logic [WIDTH-1:0] O;
    logic             COUT;
    logic             VALID_OUT;
`ifdef PIPE_ADDSUB_OVF_EN
    logic             V;
`endif

`ifdef PIPE_ADDSUB_OVF_EN
    modport master (
        output I0, I1, CIN, SUB, VALID_IN, HOLD,
        input  O, COUT, VALID_OUT, V
    );

    modport slave (
        input  I0, I1, CIN, SUB, VALID_IN, HOLD,
        output O, COUT, VALID_OUT, V
    );
`else
    modport master (
        output I0, I1, CIN, SUB, VALID_IN, HOLD,
        input  O, COUT, VALID_OUT
    );

    modport slave (
        input  I0, I1, CIN, SUB, VALID_IN, HOLD,
        output O, COUT, VALID_OUT
    );
`endif
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined WIDTH-bit adder/subtractor for iCE40.
//
// The carry chain is cut into STAGES segments of SEG = WIDTH/STAGES bits. Each segment is a
// ripple of per-bit full-adder slices (carry = majority, the SB_CARRY function; sum = 3-input
// XOR in the slice LUT). The carry out of each segment is registered and consumed by the next
// segment one cycle later, so latency is STAGES cycles and throughput is one operation per
// cycle. Operand bits still waiting for their segment, finished result bits, SUB and VALID all
// travel through the same register stages, so a transaction leaves the pipe as one word.
//
// Subtract is done as A + ~B + ~CIN; the final chain carry is inverted to report a borrow.
//
// Build option: define PIPE_ADDSUB_OVF_EN to add the registered signed-overflow output V.
//
// Parameters
//   WIDTH   operand/result width, >= 1
//   STAGES  pipeline segments = latency in cycles, 1..WIDTH, must divide WIDTH
//
// Ports
//   CLKIN   clock, all registers on the rising edge
//   RESET   asynchronous active-high reset, clears every pipeline register
//   bus     pipe_addsub_if.slave: I0, I1, CIN, SUB, VALID_IN, HOLD in;
//           O, COUT, VALID_OUT (and V) out
module pipe_addsub #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input logic         CLKIN,
    input logic         RESET,
    pipe_addsub_if.slave bus
);

    // Bad parameters stop elaboration instead of building a wrong pipe.
    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipe_addsub: STAGES must be in 1..WIDTH");
    end else if ((WIDTH % STAGES) != 0) begin : g_bad_split
        $error("pipe_addsub: WIDTH must be a multiple of STAGES");
    end

    localparam int unsigned SEG  = (STAGES == 0) ? 1 : WIDTH / STAGES;
    localparam int unsigned LAST = (STAGES == 0) ? 0 : STAGES - 1;
    localparam int unsigned MSB  = WIDTH - 1;

    // ------------------------------------------------------------------------------------------
    // Pipeline registers. Entry k holds the transaction after segment k has been added.
    // a_q/b_q keep the full operand word; bits of segments already done are simply not read
    // again and the last entry only exists to keep the indexing uniform.
    // b_q holds the operand after the subtract inversion.
    // ------------------------------------------------------------------------------------------
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             sub_q [STAGES];
    logic             vld_q [STAGES];

    // Inputs to segment k: stage 0 is fed from the ports, later stages from entry k-1.
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic             sub_in [STAGES];
    logic             vld_in [STAGES];

    // Segment results, loaded into entry k on the next non-held edge.
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];

    // ------------------------------------------------------------------------------------------
    // Segment input selection
    // ------------------------------------------------------------------------------------------
    always_comb begin
        // Stage 0: conditional inversion for subtract happens once, at entry.
        a_in[0]   = bus.I0;
        b_in[0]   = bus.SUB ? ~bus.I1 : bus.I1;
        s_in[0]   = '0;
        c_in[0]   = bus.SUB ? ~bus.CIN : bus.CIN;
        sub_in[0] = bus.SUB;
        vld_in[0] = bus.VALID_IN;

        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
            c_in[k]   = c_q[k-1];
            sub_in[k] = sub_q[k-1];
            vld_in[k] = vld_q[k-1];
        end
    end

    // ------------------------------------------------------------------------------------------
    // Carry chain: segment k ripples through bits [k*SEG +: SEG] starting from c_in[k].
    // Each bit is one full-adder slice: carry is the SB_CARRY majority function, sum the LUT.
    // Result bits outside the segment pass through unchanged.
    // ------------------------------------------------------------------------------------------
    always_comb begin : carry_chain
        logic c;
        c = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_in[k];
            c      = c_in[k];
            for (int j = 0; j < SEG; j++) begin
                s_d[k][k*SEG+j] = a_in[k][k*SEG+j] ^ b_in[k][k*SEG+j] ^ c;
                c = (a_in[k][k*SEG+j] & b_in[k][k*SEG+j]) |
                    (c & (a_in[k][k*SEG+j] ^ b_in[k][k*SEG+j]));
            end
            c_d[k] = c;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Pipeline state. HOLD freezes everything including the valid bits; RESET overrides HOLD.
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                vld_q[k] <= 1'b0;
            end
        end else if (!bus.HOLD) begin
            // Data loads regardless of VALID_IN; only the valid bit tells the consumer.
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                sub_q[k] <= sub_in[k];
                vld_q[k] <= vld_in[k];
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Outputs. c_q and sub_q are both cleared by reset, so COUT resets to 0 as well.
    // In subtract mode a missing chain carry means a borrow.
    // ------------------------------------------------------------------------------------------
    assign bus.O         = s_q[LAST];
    assign bus.COUT      = c_q[LAST] ^ sub_q[LAST];
    assign bus.VALID_OUT = vld_q[LAST];

`ifdef PIPE_ADDSUB_OVF_EN
    // Signed overflow = carry into MSB xor carry out of MSB, taken on the raw chain (before the
    // borrow inversion). The MSB lives in the last segment; its carry-in is recovered from the
    // sum bit as sum ^ a ^ b.
    logic v_d;
    logic v_q;

    always_comb begin
        v_d = s_d[LAST][MSB] ^ a_in[LAST][MSB] ^ b_in[LAST][MSB] ^ c_d[LAST];
    end

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            v_q <= 1'b0;
        end else if (!bus.HOLD) begin
            v_q <= v_d;
        end
    end

    assign bus.V = v_q;
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed bench for pipe_addsub (WIDTH=8, STAGES=2) plus a WIDTH=16 sweep
// over STAGES = 1, 4 and 16 against a plain arithmetic model.
module tb_pipe_addsub;

    logic CLKIN = 1'b0;
    logic RESET = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 CLKIN = ~CLKIN;

    pipe_addsub_if #(.WIDTH(8))  bus ();
    pipe_addsub_if #(.WIDTH(16)) bus_s1 ();
    pipe_addsub_if #(.WIDTH(16)) bus_s4 ();
    pipe_addsub_if #(.WIDTH(16)) bus_s16 ();

    pipe_addsub #(.WIDTH(8), .STAGES(2)) dut (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .bus   (bus)
    );

    pipe_addsub #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .bus   (bus_s1)
    );

    pipe_addsub #(.WIDTH(16), .STAGES(4)) dut_s4 (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .bus   (bus_s4)
    );

    pipe_addsub #(.WIDTH(16), .STAGES(16)) dut_s16 (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .bus   (bus_s16)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic vld);
        bus.I0       = a;
        bus.I1       = b;
        bus.CIN      = cin;
        bus.SUB      = sub;
        bus.VALID_IN = vld;
    endtask

    task automatic drive_wide(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic sub, input logic vld);
        bus_s1.I0  = a;   bus_s1.I1  = b;   bus_s1.CIN  = cin;
        bus_s1.SUB = sub; bus_s1.VALID_IN  = vld;
        bus_s4.I0  = a;   bus_s4.I1  = b;   bus_s4.CIN  = cin;
        bus_s4.SUB = sub; bus_s4.VALID_IN  = vld;
        bus_s16.I0 = a;   bus_s16.I1 = b;   bus_s16.CIN = cin;
        bus_s16.SUB = sub; bus_s16.VALID_IN = vld;
    endtask

    task automatic test_reset();
        bus.HOLD     = 1'b0;
        bus_s1.HOLD  = 1'b0;
        bus_s4.HOLD  = 1'b0;
        bus_s16.HOLD = 1'b0;
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive_wide(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b1;
        #2;
        checks++; if (bus.O !== 8'h00) begin
            errors++; $display("FAIL reset_o: got %h expected 00", bus.O);
        end
        checks++; if (bus.COUT !== 1'b0) begin
            errors++; $display("FAIL reset_cout: got %b expected 0", bus.COUT);
        end
        checks++; if (bus.VALID_OUT !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", bus.VALID_OUT);
        end
`ifdef PIPE_ADDSUB_OVF_EN
        checks++; if (bus.V !== 1'b0) begin
            errors++; $display("FAIL reset_v: got %b expected 0", bus.V);
        end
`endif
        tick();
        tick();
        @(negedge CLKIN);
        RESET = 1'b0;
    endtask

    task automatic test_add();
        drive(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.VALID_OUT !== 1'b0) begin
            errors++; $display("FAIL add_early_valid: got %b expected 0", bus.VALID_OUT);
        end
        tick();
        checks++; if (bus.VALID_OUT !== 1'b1) begin
            errors++; $display("FAIL add_valid: got %b expected 1", bus.VALID_OUT);
        end
        checks++; if (bus.O !== 8'h00) begin
            errors++; $display("FAIL add_o: got %h expected 00", bus.O);
        end
        checks++; if (bus.COUT !== 1'b1) begin
            errors++; $display("FAIL add_cout: got %b expected 1", bus.COUT);
        end
        tick();
        checks++; if (bus.VALID_OUT !== 1'b0) begin
            errors++; $display("FAIL add_valid_once: got %b expected 0", bus.VALID_OUT);
        end
    endtask

    task automatic test_sub();
        drive(8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
        tick();
        drive(8'h20, 8'h10, 1'b1, 1'b1, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if ({bus.VALID_OUT, bus.O, bus.COUT} !== {1'b1, 8'hF0, 1'b1}) begin
            errors++; $display("FAIL sub_borrow: got v=%b o=%h c=%b expected v=1 o=f0 c=1",
                               bus.VALID_OUT, bus.O, bus.COUT);
        end
        tick();
        checks++; if ({bus.VALID_OUT, bus.O, bus.COUT} !== {1'b1, 8'h0F, 1'b0}) begin
            errors++; $display("FAIL sub_noborrow: got v=%b o=%h c=%b expected v=1 o=0f c=0",
                               bus.VALID_OUT, bus.O, bus.COUT);
        end
        tick();
        checks++; if (bus.VALID_OUT !== 1'b0) begin
            errors++; $display("FAIL sub_drain: got %b expected 0", bus.VALID_OUT);
        end
    endtask

    task automatic test_back_to_back_hold();
        drive(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h05, 8'h03, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if ({bus.VALID_OUT, bus.O, bus.COUT} !== {1'b1, 8'h80, 1'b0}) begin
            errors++; $display("FAIL stream_t0: got v=%b o=%h c=%b expected v=1 o=80 c=0",
                               bus.VALID_OUT, bus.O, bus.COUT);
        end
        // Junk operands during HOLD must be ignored and the output must not advance.
        bus.HOLD = 1'b1;
        drive(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.VALID_OUT, bus.O, bus.COUT} !== {1'b1, 8'h80, 1'b0}) begin
                errors++; $display("FAIL stream_hold%0d: got v=%b o=%h c=%b expected v=1 o=80 c=0",
                                   i, bus.VALID_OUT, bus.O, bus.COUT);
            end
        end
        bus.HOLD = 1'b0;
        drive(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if ({bus.VALID_OUT, bus.O, bus.COUT} !== {1'b1, 8'h02, 1'b0}) begin
            errors++; $display("FAIL stream_t1: got v=%b o=%h c=%b expected v=1 o=02 c=0",
                               bus.VALID_OUT, bus.O, bus.COUT);
        end
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if ({bus.VALID_OUT, bus.O, bus.COUT} !== {1'b1, 8'h00, 1'b1}) begin
            errors++; $display("FAIL stream_t2: got v=%b o=%h c=%b expected v=1 o=00 c=1",
                               bus.VALID_OUT, bus.O, bus.COUT);
        end
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if ({bus.VALID_OUT, bus.O, bus.COUT} !== {1'b1, 8'h00, 1'b0}) begin
            errors++; $display("FAIL stream_t3: got v=%b o=%h c=%b expected v=1 o=00 c=0",
                               bus.VALID_OUT, bus.O, bus.COUT);
        end
        tick();
        checks++; if (bus.VALID_OUT !== 1'b0) begin
            errors++; $display("FAIL stream_drain: got %b expected 0", bus.VALID_OUT);
        end
    endtask

    task automatic test_reset_midflight();
        drive(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h33, 8'h01, 1'b1, 1'b1, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if ({bus.VALID_OUT, bus.O, bus.COUT} !== {1'b1, 8'h33, 1'b0}) begin
            errors++; $display("FAIL midrst_pre: got v=%b o=%h c=%b expected v=1 o=33 c=0",
                               bus.VALID_OUT, bus.O, bus.COUT);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if ({bus.VALID_OUT, bus.O, bus.COUT} !== {1'b0, 8'h00, 1'b0}) begin
            errors++; $display("FAIL midrst_async: got v=%b o=%h c=%b expected v=0 o=00 c=0",
                               bus.VALID_OUT, bus.O, bus.COUT);
        end
        tick();
        @(negedge CLKIN);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.VALID_OUT !== 1'b0) begin
                errors++; $display("FAIL midrst_stale%0d: got %b expected 0", i, bus.VALID_OUT);
            end
        end
    endtask

    task automatic test_reset_over_hold();
        drive(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        bus.HOLD = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        checks++; if ({bus.VALID_OUT, bus.O} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL rsthold_async: got v=%b o=%h expected v=0 o=00",
                               bus.VALID_OUT, bus.O);
        end
        tick();
        @(negedge CLKIN);
        RESET    = 1'b0;
        bus.HOLD = 1'b0;
        tick();
        checks++; if (bus.VALID_OUT !== 1'b0) begin
            errors++; $display("FAIL rsthold_after: got %b expected 0", bus.VALID_OUT);
        end
    endtask

`ifdef PIPE_ADDSUB_OVF_EN
    task automatic test_overflow();
        drive(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if ({bus.VALID_OUT, bus.V} !== 2'b11) begin
            errors++; $display("FAIL ovf_add: got v=%b ovf=%b expected v=1 ovf=1",
                               bus.VALID_OUT, bus.V);
        end
        drive(8'h40, 8'h20, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if ({bus.VALID_OUT, bus.V, bus.O} !== {2'b11, 8'h7F}) begin
            errors++; $display("FAIL ovf_sub: got v=%b ovf=%b o=%h expected v=1 ovf=1 o=7f",
                               bus.VALID_OUT, bus.V, bus.O);
        end
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if ({bus.VALID_OUT, bus.V, bus.O} !== {2'b10, 8'h60}) begin
            errors++; $display("FAIL ovf_none: got v=%b ovf=%b o=%h expected v=1 ovf=0 o=60",
                               bus.VALID_OUT, bus.V, bus.O);
        end
        tick();
    endtask
`endif

    localparam int NVEC = 300;

    task automatic test_sweep();
        logic [15:0] va [NVEC];
        logic [15:0] vb [NVEC];
        logic        vc [NVEC];
        logic        vs [NVEC];
        logic [15:0] eo [NVEC];
        logic        ec [NVEC];
        logic [16:0] full;
        logic [15:0] so [3];
        logic        sc [3];
        logic        sv [3];
        int          lat [3];
        int          idx;
        lat[0] = 1;
        lat[1] = 4;
        lat[2] = 16;
        for (int n = 0; n < NVEC; n++) begin
            va[n] = 16'($urandom);
            vb[n] = 16'($urandom);
            vc[n] = 1'($urandom);
            vs[n] = 1'($urandom);
        end
        // Corner vectors: full carry ripple, full borrow ripple, borrow-in only.
        va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; vs[0] = 1'b0;
        va[1] = 16'h0000; vb[1] = 16'h0001; vc[1] = 1'b0; vs[1] = 1'b1;
        va[2] = 16'h0000; vb[2] = 16'h0000; vc[2] = 1'b1; vs[2] = 1'b1;
        va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vc[3] = 1'b1; vs[3] = 1'b0;
        for (int n = 0; n < NVEC; n++) begin
            if (vs[n]) begin
                full  = {1'b0, va[n]} - {1'b0, vb[n]} - {16'h0, vc[n]};
                eo[n] = full[15:0];
                ec[n] = ({1'b0, va[n]} < ({1'b0, vb[n]} + {16'h0, vc[n]}));
            end else begin
                full  = {1'b0, va[n]} + {1'b0, vb[n]} + {16'h0, vc[n]};
                eo[n] = full[15:0];
                ec[n] = full[16];
            end
        end
        for (int n = 0; n < NVEC + 15; n++) begin
            if (n < NVEC) drive_wide(va[n], vb[n], vc[n], vs[n], 1'b1);
            else          drive_wide(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            tick();
            so[0] = bus_s1.O;  sc[0] = bus_s1.COUT;  sv[0] = bus_s1.VALID_OUT;
            so[1] = bus_s4.O;  sc[1] = bus_s4.COUT;  sv[1] = bus_s4.VALID_OUT;
            so[2] = bus_s16.O; sc[2] = bus_s16.COUT; sv[2] = bus_s16.VALID_OUT;
            for (int d = 0; d < 3; d++) begin
                idx = n - lat[d] + 1;
                checks++;
                if (idx >= 0 && idx < NVEC) begin
                    if ({sv[d], so[d], sc[d]} !== {1'b1, eo[idx], ec[idx]}) begin
                        errors++;
                        $display("FAIL sweep_s%0d_vec%0d: got v=%b o=%h c=%b expected v=1 o=%h c=%b",
                                 lat[d], idx, sv[d], so[d], sc[d], eo[idx], ec[idx]);
                    end
                end else if (sv[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_s%0d_idle%0d: got v=%b expected v=0", lat[d], n, sv[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back_hold();
        test_reset_midflight();
        test_reset_over_hold();
`ifdef PIPE_ADDSUB_OVF_EN
        test_overflow();
`endif
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
